// File: rtl/wb_port_arbiter.sv
// Round-robin arbiter that lets NREQ requesters share one register-file write port.
// Optional macro ARB_LOCK_EN adds a per-requester lock input that lets the current winner hold the port for up to 8 grants.
module wb_port_arbiter #(
  parameter int NREQ = 4,
  parameter int AW   = 5,
  parameter int DW   = 32
) (
  input  logic               clock,
  input  logic               clearb,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*AW-1:0] waddr_i,
  input  logic [NREQ*DW-1:0] wdata_i,
`ifdef ARB_LOCK_EN
  input  logic [NREQ-1:0]    lock,
`endif
  output logic [NREQ-1:0]    gnt,
  output logic               rf_we,
  output logic [AW-1:0]      rf_waddr,
  output logic [DW-1:0]      rf_wdata,
  output logic               busy
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   ptr_q, ptr_d;
  logic [NREQ-1:0] gnt_q, gnt_d;
  logic            rf_we_q, rf_we_d;
  logic [AW-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DW-1:0]   rf_wdata_q, rf_wdata_d;

  logic [NREQ-1:0] eligible;
  logic [PW-1:0]   scan_idx;
  logic [PW-1:0]   win;
  logic            found;
  logic [PW-1:0]   sel;
  logic            take;
  logic [AW-1:0]   sel_addr;

`ifdef ARB_LOCK_EN
  logic [2:0]      lock_cnt_q, lock_cnt_d;
  logic [PW-1:0]   cur;
  logic            lock_hold;
`endif

  // A requester that holds the grant this cycle sits out the next edge.
  assign eligible = req & ~gnt_q;

  always_comb begin
    found    = 1'b0;
    win      = '0;
    scan_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_idx = PW'((int'(ptr_q) + k) % NREQ);
      if (!found && eligible[scan_idx]) begin
        found = 1'b1;
        win   = scan_idx;
      end
    end
  end

`ifdef ARB_LOCK_EN
  // Re-grant the current owner while it keeps lock and req, until 7 re-grants have been given.
  always_comb begin
    cur = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (gnt_q[k]) cur = PW'(k);
    end
    lock_hold = (|(gnt_q & req & lock)) && (lock_cnt_q != 3'd7);
  end
`endif

  always_comb begin
    ptr_d      = ptr_q;
    gnt_d      = '0;
    rf_we_d    = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    sel        = '0;
    take       = 1'b0;
    sel_addr   = '0;
`ifdef ARB_LOCK_EN
    lock_cnt_d = '0;
    if (lock_hold) begin
      take       = 1'b1;
      sel        = cur;
      lock_cnt_d = lock_cnt_q + 3'd1;
    end else
`endif
    if (found) begin
      take  = 1'b1;
      sel   = win;
      ptr_d = PW'((int'(win) + 1) % NREQ);
    end
    if (take) begin
      sel_addr   = waddr_i[int'(sel)*AW +: AW];
      gnt_d      = {{(NREQ-1){1'b0}}, 1'b1} << sel;
      rf_waddr_d = sel_addr;
      rf_wdata_d = wdata_i[int'(sel)*DW +: DW];
      rf_we_d    = |sel_addr;
    end
  end

  always_ff @(posedge clock or negedge clearb) begin
    if (!clearb) begin
      ptr_q      <= '0;
      gnt_q      <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      ptr_q      <= ptr_d;
      gnt_q      <= gnt_d;
      rf_we_q    <= rf_we_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

`ifdef ARB_LOCK_EN
  always_ff @(posedge clock or negedge clearb) begin
    if (!clearb) lock_cnt_q <= '0;
    else         lock_cnt_q <= lock_cnt_d;
  end
`endif

  assign gnt      = gnt_q;
  assign rf_we    = rf_we_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign busy     = |gnt_q;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus randomized handshakes
// compared against a behavioural round-robin model (lock scenarios when ARB_LOCK_EN is defined).
module tb_wb_port_arbiter;

  logic         clock;
  logic         clearb;
  logic [3:0]   req;
  logic [19:0]  waddr_i;
  logic [127:0] wdata_i;
`ifdef ARB_LOCK_EN
  logic [3:0]   lock;
`endif
  logic [3:0]   gnt;
  logic         rf_we;
  logic [4:0]   rf_waddr;
  logic [31:0]  rf_wdata;
  logic         busy;

  int tests_run = 0;
  int tests_failed = 0;

  // behavioural model state
  int          m_gnt;
  int          m_ptr;
  int          m_lock_cnt;
  logic        m_we;
  logic [4:0]  m_addr;
  logic [31:0] m_data;

  wb_port_arbiter #(.NREQ(4), .AW(5), .DW(32)) dut (
    .clock    (clock),
    .clearb   (clearb),
    .req      (req),
    .waddr_i  (waddr_i),
    .wdata_i  (wdata_i),
`ifdef ARB_LOCK_EN
    .lock     (lock),
`endif
    .gnt      (gnt),
    .rf_we    (rf_we),
    .rf_waddr (rf_waddr),
    .rf_wdata (rf_wdata),
    .busy     (busy)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [3:0] onehot(input int g);
    logic [3:0] v;
    v = 4'b0000;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  task automatic model_reset();
    m_gnt = -1;
    m_ptr = 0;
    m_lock_cnt = 0;
    m_we = 1'b0;
    m_addr = '0;
    m_data = '0;
  endtask

  // One arbitration decision from the current inputs, expressed as plain integer rules.
  task automatic model_edge();
    int w;
    w = -1;
`ifdef ARB_LOCK_EN
    if (m_gnt >= 0 && req[m_gnt] && lock[m_gnt] && m_lock_cnt < 7) begin
      w = m_gnt;
      m_lock_cnt++;
    end
`endif
    if (w < 0) begin
      m_lock_cnt = 0;
      for (int off = 0; off < 4; off++) begin
        int i;
        i = (m_ptr + off) % 4;
        if (w < 0 && req[i] && i != m_gnt) w = i;
      end
      if (w >= 0) m_ptr = (w + 1) % 4;
    end
    if (w >= 0) begin
      m_addr = waddr_i[w*5 +: 5];
      m_data = wdata_i[w*32 +: 32];
      m_we   = (m_addr != 5'd0);
    end else begin
      m_we = 1'b0;
    end
    m_gnt = w;
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic do_reset();
    clearb = 1'b0;
    req = 4'b0000;
`ifdef ARB_LOCK_EN
    lock = 4'b0000;
`endif
    model_reset();
    #1;
    @(negedge clock);
    clearb = 1'b1;
  endtask

  task automatic test_reset();
    clearb = 1'b1;
    req = 4'b1111;
    waddr_i = {5'd9, 5'd8, 5'd7, 5'd6};
    wdata_i = {32'h4, 32'h3, 32'h2, 32'h1};
    @(posedge clock);
    #2;
    clearb = 1'b0;
    #1;
    tests_run++;
    if ({gnt, rf_we, busy} !== 6'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin
      tests_failed++;
      $display("[TB] FAIL reset_outputs: got gnt=%b we=%b busy=%b addr=%0d data=%h, expected all zero",
               gnt, rf_we, busy, rf_waddr, rf_wdata);
    end
    do_reset();
  endtask

  task automatic test_single_write();
    do_reset();
    waddr_i[4:0] = 5'd5;
    wdata_i[31:0] = 32'hDEADBEEF;
    req = 4'b0001;
    step();
    tests_run++;
    if (gnt !== 4'b0001 || rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL single_write: got gnt=%b we=%b addr=%0d data=%h busy=%b, expected 0001 1 5 deadbeef 1",
               gnt, rf_we, rf_waddr, rf_wdata, busy);
    end
    req = 4'b0000;
    step();
    tests_run++;
    if (gnt !== 4'b0000 || rf_we !== 1'b0 || busy !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF) begin
      tests_failed++;
      $display("[TB] FAIL idle_hold: got gnt=%b we=%b busy=%b addr=%0d data=%h, expected 0000 0 0 5 deadbeef",
               gnt, rf_we, busy, rf_waddr, rf_wdata);
    end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_seq [5];
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    do_reset();
    waddr_i = {5'd4, 5'd3, 5'd2, 5'd1};
    wdata_i = {32'hD, 32'hC, 32'hB, 32'hA};
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      step();
      tests_run++;
      if (gnt !== exp_seq[n]) begin
        tests_failed++;
        $display("[TB] FAIL round_robin[%0d]: got gnt=%b expected %b", n, gnt, exp_seq[n]);
      end
    end
    req = 4'b0000;
  endtask

  task automatic test_zero_addr();
    do_reset();
    waddr_i[14:10] = 5'd0;
    wdata_i[95:64] = 32'h1234_5678;
    req = 4'b0100;
    step();
    tests_run++;
    if (gnt !== 4'b0100 || rf_we !== 1'b0 || busy !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL zero_addr: got gnt=%b we=%b busy=%b, expected 0100 0 1", gnt, rf_we, busy);
    end
    req = 4'b0000;
    step();
    tests_run++;
    if (gnt !== 4'b0000 || rf_we !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL zero_addr_release: got gnt=%b we=%b, expected 0000 0", gnt, rf_we);
    end
  endtask

  task automatic test_reset_mid_grant();
    do_reset();
    waddr_i = {5'd4, 5'd3, 5'd2, 5'd1};
    req = 4'b0011;
    step();
    step();
    tests_run++;
    if (gnt !== 4'b0010 || rf_we !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL pre_reset_grant: got gnt=%b we=%b, expected 0010 1", gnt, rf_we);
    end
    clearb = 1'b0;
    #1;
    tests_run++;
    if (gnt !== 4'b0000 || rf_we !== 1'b0 || busy !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL async_reset: got gnt=%b we=%b busy=%b, expected 0000 0 0", gnt, rf_we, busy);
    end
    model_reset();
    @(negedge clock);
    clearb = 1'b1;
    req = 4'b0011;
    step();
    tests_run++;
    if (gnt !== 4'b0001 || rf_waddr !== 5'd1) begin
      tests_failed++;
      $display("[TB] FAIL post_reset_grant: got gnt=%b addr=%0d, expected 0001 1", gnt, rf_waddr);
    end
    req = 4'b0000;
  endtask

`ifdef ARB_LOCK_EN
  task automatic test_lock();
    logic [3:0] exp_g;
    do_reset();
    waddr_i = {5'd4, 5'd3, 5'd2, 5'd1};
    req = 4'b0011;
    lock = 4'b0001;
    for (int n = 0; n < 10; n++) begin
      step();
      exp_g = (n < 8) ? 4'b0001 : ((n == 8) ? 4'b0010 : 4'b0001);
      tests_run++;
      if (gnt !== exp_g) begin
        tests_failed++;
        $display("[TB] FAIL lock[%0d]: got gnt=%b expected %b", n, gnt, exp_g);
      end
    end
    req = 4'b0000;
    lock = 4'b0000;
  endtask
`endif

  // Randomized requesters obeying the hold-until-granted handshake.
  task automatic test_random();
    logic [3:0] exp_g;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      for (int i = 0; i < 4; i++) begin
        if (m_gnt == i) begin
`ifdef ARB_LOCK_EN
          if (!(lock[i] && $urandom_range(0, 3) != 0)) req[i] = 1'b0;
`else
          req[i] = 1'b0;
`endif
        end else if (!req[i] && $urandom_range(0, 2) == 0) begin
          req[i] = 1'b1;
          waddr_i[i*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
          wdata_i[i*32 +: 32] = $urandom;
        end
      end
`ifdef ARB_LOCK_EN
      lock = 4'($urandom) & 4'($urandom);
`endif
      step();
      exp_g = onehot(m_gnt);
      tests_run++;
      if (gnt !== exp_g || busy !== (m_gnt >= 0)) begin
        tests_failed++;
        $display("[TB] FAIL random_gnt[%0d]: got gnt=%b busy=%b expected %b", n, gnt, busy, exp_g);
      end
      tests_run++;
      if (rf_we !== m_we || rf_waddr !== m_addr || rf_wdata !== m_data) begin
        tests_failed++;
        $display("[TB] FAIL random_rf[%0d]: got we=%b addr=%0d data=%h expected we=%b addr=%0d data=%h",
                 n, rf_we, rf_waddr, rf_wdata, m_we, m_addr, m_data);
      end
    end
    req = 4'b0000;
  endtask

  initial begin
    clearb = 1'b0;
    req = 4'b0000;
    waddr_i = '0;
    wdata_i = '0;
`ifdef ARB_LOCK_EN
    lock = 4'b0000;
`endif
    model_reset();
    test_reset();
    test_single_write();
    test_round_robin();
    test_zero_addr();
    test_reset_mid_grant();
`ifdef ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
